// File: rtl/touch_led_mode_ctrl.sv
// ============================================================================
// Module      : touch_led_mode_ctrl
// Description : Debounced touch-key press classifier driving a four-mode
//               (OFF / ON / SLOW blink / FAST blink) active-low LED.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module touch_led_mode_ctrl #(
    parameter int DEB_CNT   = 1_000_000,
    parameter int LONG_CNT  = 50_000_000,
    parameter int SLOW_HALF = 25_000_000,
    parameter int FAST_HALF = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       touch_key,
    output logic       led,
    output logic [1:0] mode,
    output logic       short_pulse,
    output logic       long_pulse
);

    localparam int c_DEB_W  = (DEB_CNT > 1)  ? $clog2(DEB_CNT)  : 1;
    localparam int c_HOLD_W = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
    localparam int c_SLOW_W = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam int c_FAST_W = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
    localparam int c_BLK_W  = (c_SLOW_W > c_FAST_W) ? c_SLOW_W : c_FAST_W;

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CNT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CNT - 1);
    localparam logic [c_BLK_W-1:0]  c_SLOW_LAST = c_BLK_W'(SLOW_HALF - 1);
    localparam logic [c_BLK_W-1:0]  c_FAST_LAST = c_BLK_W'(FAST_HALF - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PRESSED = 2'd1;
    localparam logic [1:0] c_ST_LONG    = 2'd2;

    localparam logic [1:0] c_MODE_OFF  = 2'd0;
    localparam logic [1:0] c_MODE_ON   = 2'd1;
    localparam logic [1:0] c_MODE_SLOW = 2'd2;
    localparam logic [1:0] c_MODE_FAST = 2'd3;

    logic                r_key_meta;
    logic                r_key_sync;
    logic                r_key_stable;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_short_pulse;
    logic                r_long_pulse;
    logic [1:0]          r_mode;
    logic [c_BLK_W-1:0]  r_blink_cnt;
    logic                r_phase;
    logic                r_led;
    logic [c_BLK_W-1:0]  w_half_last;
    logic                w_blinking;

    assign w_blinking  = (r_mode == c_MODE_SLOW) || (r_mode == c_MODE_FAST);
    assign w_half_last = (r_mode == c_MODE_SLOW) ? c_SLOW_LAST : c_FAST_LAST;

    // Two-flop synchroniser followed by a stable-level debouncer.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_key_meta   <= 1'b1;
            r_key_sync   <= 1'b1;
            r_key_stable <= 1'b1;
            r_deb_cnt    <= '0;
        end else begin
            r_key_meta <= touch_key;
            r_key_sync <= r_key_meta;
            if (r_key_sync != r_key_stable) begin
                if (r_deb_cnt == c_DEB_LAST) begin
                    r_key_stable <= r_key_sync;
                    r_deb_cnt    <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // In IDLE the stable key can only be low right after a falling edge,
    // since every path back to IDLE requires it to be high.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= c_ST_IDLE;
            r_hold_cnt    <= '0;
            r_short_pulse <= 1'b0;
            r_long_pulse  <= 1'b0;
        end else begin
            r_short_pulse <= 1'b0;
            r_long_pulse  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_key_stable) begin
                        r_state    <= c_ST_PRESSED;
                        r_hold_cnt <= '0;
                    end
                end
                c_ST_PRESSED: begin
                    if (r_hold_cnt != c_HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                    if (r_key_stable) begin
                        r_state       <= c_ST_IDLE;
                        r_short_pulse <= 1'b1;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state      <= c_ST_LONG;
                        r_long_pulse <= 1'b1;
                    end
                end
                c_ST_LONG: begin
                    if (r_key_stable) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_mode <= c_MODE_OFF;
        end else if (r_long_pulse) begin
            r_mode <= c_MODE_OFF;
        end else if (r_short_pulse) begin
            r_mode <= r_mode + 2'd1;
        end
    end

    // Mode changes restart the blink so each blink mode opens with a full lit phase.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_short_pulse || r_long_pulse) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_blinking) begin
            if (r_blink_cnt == w_half_last) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blink_cnt <= '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_led <= 1'b1;
        end else begin
            case (r_mode)
                c_MODE_OFF: r_led <= 1'b1;
                c_MODE_ON:  r_led <= 1'b0;
                default:    r_led <= ~r_phase;
            endcase
        end
    end

    assign led         = r_led;
    assign mode        = r_mode;
    assign short_pulse = r_short_pulse;
    assign long_pulse  = r_long_pulse;

endmodule

`default_nettype wire

// File: tb/tb_touch_led_mode_ctrl.sv
// ============================================================================
// Module      : tb_touch_led_mode_ctrl
// Description : Directed self-checking bench for touch_led_mode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_touch_led_mode_ctrl;

    localparam int c_DEB  = 4;
    localparam int c_LONG = 20;
    localparam int c_SLOW = 8;
    localparam int c_FAST = 3;
    // Pin edge -> key_stable is 2 + DEB cycles, the registered FSM adds one.
    localparam int c_REL_LAT  = 2 + c_DEB + 1;
    // key_stable low -> PRESSED takes one cycle, then LONG cycles of holding.
    localparam int c_LONG_LAT = 2 + c_DEB + 1 + c_LONG;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       r_key;
    logic       w_led;
    logic [1:0] w_mode;
    logic       w_short;
    logic       w_long;

    int r_cyc     = 0;
    int r_n_short = 0;
    int r_n_long  = 0;
    int n_checks  = 0;
    int n_fails   = 0;

    touch_led_mode_ctrl #(
        .DEB_CNT   (c_DEB),
        .LONG_CNT  (c_LONG),
        .SLOW_HALF (c_SLOW),
        .FAST_HALF (c_FAST)
    ) u_dut (
        .sys_clk     (r_clk),
        .sys_rst     (r_rst),
        .touch_key   (r_key),
        .led         (w_led),
        .mode        (w_mode),
        .short_pulse (w_short),
        .long_pulse  (w_long)
    );

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) r_cyc <= r_cyc + 1;

    always @(negedge r_clk) begin
        if (w_short) r_n_short <= r_n_short + 1;
        if (w_long)  r_n_long  <= r_n_long + 1;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge r_clk);
    endtask

    task automatic short_press(input int low_cyc);
        int t_rel;
        int t_pulse;
        @(negedge r_clk);
        r_key = 1'b0;
        tick(low_cyc);
        r_key = 1'b1;
        t_rel   = r_cyc;
        t_pulse = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge r_clk);
            if (w_short) begin
                t_pulse = r_cyc;
                break;
            end
        end
        check_eq("short_seen", (t_pulse >= 0) ? 1 : 0, 1);
        check_eq("short_lat", t_pulse - t_rel, c_REL_LAT);
    endtask

    // Call right after short_press; checks the mode and a steady-mode LED.
    task automatic check_steady(input int exp_mode, input int exp_led);
        @(negedge r_clk);
        check_eq("mode_after_pulse", w_mode, exp_mode);
        @(negedge r_clk);
        check_eq("led_after_mode", w_led, exp_led);
    endtask

    // Sample s (s >= 2) after the pulse: lit for HALF samples, dark for HALF.
    task automatic check_blink(input int half, input int exp_mode);
        for (int s = 1; s <= 4 * half + 1; s++) begin
            @(negedge r_clk);
            if (s == 1) check_eq("blink_mode", w_mode, exp_mode);
            else        check_eq("blink_led", w_led, ((s - 2) / half) % 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int l0;
        int t_p;
        int t_l;
        r_rst = 1'b1;
        r_key = 1'b1;
        tick(3);
        check_eq("rst_led", w_led, 1);
        check_eq("rst_mode", w_mode, 0);
        check_eq("rst_short", w_short, 0);
        check_eq("rst_long", w_long, 0);
        r_rst = 1'b0;

        // Idle with key released.
        for (int i = 0; i < 10; i++) begin
            tick(10);
            check_eq("idle_led", w_led, 1);
            check_eq("idle_mode", w_mode, 0);
        end
        check_eq("idle_short_cnt", r_n_short, 0);
        check_eq("idle_long_cnt", r_n_long, 0);

        // First short press: OFF -> ON; led still dark the cycle mode updates.
        short_press(10);
        @(negedge r_clk);
        check_eq("p1_mode", w_mode, 1);
        check_eq("p1_led_lag", w_led, 1);
        @(negedge r_clk);
        check_eq("p1_led", w_led, 0);
        tick(20);
        check_eq("p1_short_cnt", r_n_short, 1);
        check_eq("p1_long_cnt", r_n_long, 0);

        // Glitches shorter than the debounce window are ignored.
        s0 = r_n_short;
        l0 = r_n_long;
        r_key = 1'b0; tick(3); r_key = 1'b1;
        tick(10);
        r_key = 1'b0; tick(2); r_key = 1'b1; tick(2);
        r_key = 1'b0; tick(2); r_key = 1'b1;
        tick(15);
        check_eq("glitch_short", r_n_short, s0);
        check_eq("glitch_long", r_n_long, l0);
        check_eq("glitch_mode", w_mode, 1);
        check_eq("glitch_led", w_led, 0);

        // Mode stepping with blink timing.
        short_press(8);
        check_blink(c_SLOW, 2);
        short_press(8);
        check_blink(c_FAST, 3);
        short_press(8);
        check_steady(0, 1);
        short_press(8);
        check_steady(1, 0);
        short_press(8);
        check_blink(c_SLOW, 2);

        // Long press from SLOW forces OFF; its release gives no short pulse.
        s0 = r_n_short;
        l0 = r_n_long;
        @(negedge r_clk);
        r_key = 1'b0;
        t_p = r_cyc;
        t_l = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge r_clk);
            if (t_l >= 0 && r_cyc == t_l + 1) check_eq("long_mode", w_mode, 0);
            if (t_l >= 0 && r_cyc == t_l + 2) check_eq("long_led", w_led, 1);
            if (w_long && t_l < 0) t_l = r_cyc;
        end
        r_key = 1'b1;
        check_eq("long_lat", t_l - t_p, c_LONG_LAT);
        tick(20);
        check_eq("long_cnt", r_n_long, l0 + 1);
        check_eq("long_no_short", r_n_short, s0);
        check_eq("long_rel_mode", w_mode, 0);
        check_eq("long_rel_led", w_led, 1);

        // Asynchronous reset mid-press.
        short_press(8);
        check_steady(1, 0);
        tick(3);
        r_key = 1'b0;
        tick(12);
        #2 r_rst = 1'b1;
        #1;
        check_eq("rstp_led", w_led, 1);
        check_eq("rstp_mode", w_mode, 0);
        check_eq("rstp_short", w_short, 0);
        check_eq("rstp_long", w_long, 0);
        r_key = 1'b1;
        tick(3);
        r_rst = 1'b0;
        s0 = r_n_short;
        tick(20);
        check_eq("rstp_no_short", r_n_short, s0);
        check_eq("rstp_mode_hold", w_mode, 0);

        // Asynchronous reset mid-blink in FAST.
        short_press(8);
        check_steady(1, 0);
        short_press(8);
        check_steady(2, 0);
        short_press(8);
        tick(3);
        check_eq("rstb_pre_mode", w_mode, 3);
        check_eq("rstb_pre_led", w_led, 0);
        #2 r_rst = 1'b1;
        #1;
        check_eq("rstb_led", w_led, 1);
        check_eq("rstb_mode", w_mode, 0);
        check_eq("rstb_short", w_short, 0);
        check_eq("rstb_long", w_long, 0);
        tick(2);
        r_rst = 1'b0;
        tick(5);
        short_press(8);
        check_steady(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
